// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the SNN configuration loader: FSM states, frame geometry,
// the reserved clear-command address and the network parameter register map.
// Latency: n/a (package). Backpressure: n/a.
package snn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DISCARD = 2'd2,
        COMMIT  = 2'd3
    } cfg_state_t;

    localparam int CFG_ADDR_W = 4;
    localparam int CFG_DATA_W = 8;
    localparam int FRAME_BITS = CFG_ADDR_W + CFG_DATA_W;

    // Address 15 never reaches the register file; it clears the sticky error flags.
    localparam logic [3:0] CLEAR_CMD_ADDR = 4'd15;

    // Network parameter register map.
    localparam logic [3:0] ADDR_THRESHOLD     = 4'd0;
    localparam logic [3:0] ADDR_LEAK_RATE     = 4'd1;
    localparam logic [3:0] ADDR_REFRAC_PERIOD = 4'd2;
    localparam logic [3:0] ADDR_L1_W0 = 4'd3,  ADDR_L1_W1 = 4'd4,  ADDR_L1_W2 = 4'd5;
    localparam logic [3:0] ADDR_L2_W0 = 4'd6,  ADDR_L2_W1 = 4'd7,  ADDR_L2_W2 = 4'd8;
    localparam logic [3:0] ADDR_L2_W3 = 4'd9,  ADDR_L2_W4 = 4'd10, ADDR_L2_W5 = 4'd11;
    localparam logic [3:0] ADDR_L2_W6 = 4'd12, ADDR_L2_W7 = 4'd13, ADDR_L2_W8 = 4'd14;

endpackage

// File: rtl/snn_cfg_shift_rx.sv
// Bit-serial receiver datapath: shift register, bit counter and inter-bit timeout counter.
// Latency: one cycle per accepted bit; status outputs are combinational on register state.
// Backpressure: none; the parent FSM decides when a bit is accepted via i_shift.
// Ports: i_clk/i_rst_n (sync, active low); i_clear restarts count and timeout, i_shift
// accepts i_sdata, i_tmo_inc ages the gap counter; o_word is the received bits (MSB first),
// o_full flags a complete word, o_tmo_hit flags the gap reaching TIMEOUT_CYCLES this cycle.
module snn_cfg_shift_rx #(
    parameter int NBITS          = 12,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_sdata,
    input  logic             i_tmo_inc,
    output logic [NBITS-1:0] o_word,
    output logic             o_full,
    output logic             o_tmo_hit
);
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NBITS-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [TMO_W-1:0] r_tmo;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_tmo  <= '0;
        end else begin
            if (i_shift)
                r_sreg <= {r_sreg[NBITS-2:0], i_sdata};
            // A clear in the same cycle as a bit counts that bit as the first one.
            if (i_clear)
                r_cnt <= i_shift ? CNT_W'(1) : '0;
            else if (i_shift)
                r_cnt <= r_cnt + CNT_W'(1);
            if (i_clear || i_shift)
                r_tmo <= '0;
            else if (i_tmo_inc)
                r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    assign o_word    = r_sreg;
    assign o_full    = (r_cnt == CNT_W'(NBITS));
    // Fires on the edge at which the gap would reach TIMEOUT_CYCLES.
    assign o_tmo_hit = i_tmo_inc && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/snn_config_loader.sv
// Framed bit-serial to parallel config writer feeding the SNN parameter register file.
// Latency: frame sampled low at edge N -> cfg_we high from edge N+1 to N+2.
// Backpressure: none; busy reports an open/discarding/committing frame, excess bits flag err_long.
// Ports: clk, reset (sync, active low); frame/bit_valid/sdata serial input; cfg_addr/cfg_data/
// cfg_we write port; busy; sticky err_short/err_long/err_timeout; write_count (wraps).
// Option SNN_CFG_PARITY_EN: adds a trailing even-parity bit per frame and the err_parity port.
module snn_config_loader
    import snn_cfg_pkg::*;
#(
    parameter int ADDR_W         = CFG_ADDR_W,
    parameter int DATA_W         = CFG_DATA_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame,
    input  logic              bit_valid,
    input  logic              sdata,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_we,
    output logic              busy,
    output logic              err_short,
    output logic              err_long,
    output logic              err_timeout,
    output logic [7:0]        write_count
`ifdef SNN_CFG_PARITY_EN
   ,output logic              err_parity
`endif
);
`ifdef SNN_CFG_PARITY_EN
    localparam int NBITS = ADDR_W + DATA_W + 1;
`else
    localparam int NBITS = ADDR_W + DATA_W;
`endif

    cfg_state_t        r_state;
    logic [NBITS-1:0]  w_word;
    logic              w_full;
    logic              w_tmo_hit;
    logic              w_clear;
    logic              w_shift;
    logic              w_tmo_inc;
    logic              w_par_ok;
    logic [ADDR_W-1:0] w_addr_f;
    logic [DATA_W-1:0] w_data_f;

    // Address field leads the frame, data follows; a parity bit, if present, is the LSB.
    assign w_addr_f = w_word[NBITS-1 -: ADDR_W];
    assign w_data_f = w_word[NBITS-ADDR_W-1 -: DATA_W];
`ifdef SNN_CFG_PARITY_EN
    assign w_par_ok = ~^w_word;
`else
    assign w_par_ok = 1'b1;
`endif

    // IDLE and COMMIT restart the receiver; only IDLE may capture a bit while restarting.
    always_comb begin
        w_clear   = 1'b0;
        w_shift   = 1'b0;
        w_tmo_inc = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                w_shift = frame && bit_valid;
            end
            SHIFT: begin
                if (frame) begin
                    if (bit_valid) w_shift   = !w_full;
                    else           w_tmo_inc = 1'b1;
                end
            end
            COMMIT:  w_clear = 1'b1;
            default: ;
        endcase
    end

    snn_cfg_shift_rx #(
        .NBITS          (NBITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_clear),
        .i_shift   (w_shift),
        .i_sdata   (sdata),
        .i_tmo_inc (w_tmo_inc),
        .o_word    (w_word),
        .o_full    (w_full),
        .o_tmo_hit (w_tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            cfg_addr    <= '0;
            cfg_data    <= '0;
            cfg_we      <= 1'b0;
            busy        <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_timeout <= 1'b0;
            write_count <= '0;
`ifdef SNN_CFG_PARITY_EN
            err_parity  <= 1'b0;
`endif
        end else begin
            cfg_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame) begin
                        r_state <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!frame) begin
                        if (w_full) begin
                            r_state <= COMMIT;
                        end else begin
                            err_short <= 1'b1;
                            r_state   <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (bit_valid) begin
                        if (w_full) begin
                            err_long <= 1'b1;
                            r_state  <= DISCARD;
                        end
                    end else if (w_tmo_hit) begin
                        err_timeout <= 1'b1;
                        r_state     <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (!frame) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (!w_par_ok) begin
`ifdef SNN_CFG_PARITY_EN
                        err_parity <= 1'b1;
`endif
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (w_addr_f == ADDR_W'(CLEAR_CMD_ADDR)) begin
                            err_short   <= 1'b0;
                            err_long    <= 1'b0;
                            err_timeout <= 1'b0;
`ifdef SNN_CFG_PARITY_EN
                            err_parity  <= 1'b0;
`endif
                        end else begin
                            cfg_addr    <= w_addr_f;
                            cfg_data    <= w_data_f;
                            cfg_we      <= 1'b1;
                            write_count <= write_count + 8'd1;
                        end
                        r_state <= frame ? SHIFT : IDLE;
                        busy    <= frame;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/snn_config_loader.md
Name: snn_config_loader

Overview:
- Serial-to-parallel configuration front end that sits directly upstream of the spiking neuron network's parameter register file.
- Receives framed bit-serial words (4-bit address + 8-bit data, MSB first) on a strobe-qualified serial input.
- Validates each frame and issues exactly one registered write (cfg_addr/cfg_data/cfg_we) per good frame. These outputs connect straight to the network's addr/data_in/write_enable.
- Tracks frame errors in sticky flags and counts committed writes.

Parameters:
- ADDR_W, 4, address field width.
- DATA_W, 8, data field width.
- TIMEOUT_CYCLES, 1023, maximum clk cycles allowed between successive bit_valid strobes while a frame is open.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- frame  input  1  frame enable; high while a word is being shifted in.
- bit_valid  input  1  one-cycle strobe; qualifies sdata.
- sdata  input  1  serial data bit, MSB first.
- cfg_addr  output  ADDR_W  address of the last committed write.
- cfg_data  output  DATA_W  data of the last committed write.
- cfg_we  output  1  one-cycle write strobe.
- busy  output  1  high in SHIFT, DISCARD and COMMIT.
- err_short  output  1  sticky: a frame closed with fewer than ADDR_W+DATA_W bits.
- err_long  output  1  sticky: a frame carried too many bits.
- err_timeout  output  1  sticky: the inter-bit gap exceeded TIMEOUT_CYCLES.
- write_count  output  8  number of committed writes; wraps 255 -> 0.

Behaviour:
- **Reset** (reset==0 at a clk edge): state=IDLE. cfg_addr=0, cfg_data=0, cfg_we=0, busy=0, all err_* =0, write_count=0, bit count=0, timeout counter=0. Reset taken mid-frame discards the partial word with no write.
- **Frame length:** FRAME_BITS = ADDR_W+DATA_W (12). Shift register is FRAME_BITS wide. Bit order is address MSB first, then data MSB first.
- **IDLE:** frame==1 -> SHIFT, bit count cleared. A bit_valid in that same cycle is captured (count=1).
- **SHIFT:**
  - Each bit_valid with frame==1 shifts sdata in, increments the count and clears the timeout counter.
  - bit_valid while count==FRAME_BITS -> err_long=1, go to DISCARD.
  - Timeout counter reaches TIMEOUT_CYCLES -> err_timeout=1, go to DISCARD.
  - frame==0 with count==FRAME_BITS -> COMMIT.
  - frame==0 with count<FRAME_BITS -> err_short=1, go to IDLE.
  - bit_valid in a cycle where frame==0 is ignored.
- **DISCARD:** waits for frame==0, then -> IDLE. No write is issued.
- **COMMIT** (exactly one cycle):
  - Address field != 15: cfg_addr/cfg_data load from the shift register, cfg_we=1 for that single cycle, write_count increments.
  - Address field == 15: reserved clear command. All err_* clear, no cfg_we, write_count unchanged.
  - Next state is SHIFT (count=0) if frame==1 in the COMMIT cycle, otherwise IDLE.
- **Latency:** frame sampled low at edge N -> COMMIT during cycle N+1 -> cfg_we visible from edge N+1 to edge N+2.
- cfg_addr/cfg_data hold their values between commits.
- An err_* flag set in the same cycle as a clear command stays cleared. The set wins only if it occurs on a later edge.

Optional Feature:
- Macro: SNN_CFG_PARITY_EN.
- Defined:
  - Frame length is FRAME_BITS+1. The final bit is even parity over all address and data bits.
  - A parity mismatch at COMMIT suppresses the write (and the clear command), sets a sticky err_parity, and returns to IDLE.
  - err_parity is an extra 1-bit output port. It is cleared by reset or by a valid clear command.
- Undefined: 12-bit frames, no parity checking, and no err_parity port.

Decomposition:
- Shared package snn_cfg_pkg holds:
  - the state enumeration (IDLE, SHIFT, DISCARD, COMMIT);
  - FRAME_BITS;
  - CLEAR_CMD_ADDR = 4'd15;
  - the network register address constants 0..14 (THRESHOLD=0, LEAK_RATE=1, REFRAC_PERIOD=2, first-layer weights 3..5, second-layer weights 6..14).
- One natural sub-module: snn_cfg_shift_rx. It contains the shift register, bit counter and timeout counter, and reports count/timeout status to the parent FSM.

Test Plan:
- Frame addr=0x0, data=0x7F, 12 bits with a 1-cycle gap between strobes, then frame low -> single cfg_we pulse 1 cycle after frame is sampled low; cfg_addr=0, cfg_data=0x7F, write_count=1.
- Frame closed after 7 bits -> err_short=1, no cfg_we, write_count unchanged. A following good frame (addr=3, data=0x20) still commits.
- 13 strobes in one frame -> err_long=1, no write; busy stays high until frame drops.
- Frame opened, 5 bits, then no strobe for 1023 cycles (TIMEOUT_CYCLES=1023) -> err_timeout=1, no write. Then a frame with addr=15, any data -> all err_* =0, no cfg_we.
- Back-to-back frames with frame re-asserted in the COMMIT cycle (addr=6 data=0x11, then addr=14 data=0xFF) -> two cfg_we pulses, write_count=2, second word intact.
- reset=0 asserted after 8 bits of a frame -> all outputs at reset values, no write. With SNN_CFG_PARITY_EN defined, a frame with a wrong parity bit -> err_parity=1 and no cfg_we.
